rsa_modexp_ctrl: RTL and testbench

Sequencer for 256-bit modular exponentiation (y^d mod N) by LSB-first square-and-multiply. It issues Montgomery products to one shared external Montgomery product unit (256-bit, start/finish handshake, 258-cycle compute) and holds the result until the next request. It sits between the RSA top-level (key/ciphertext loader) and the product unit. The Montgomery pre-processing (y·2^256 mod N) is computed upstream and supplied as an input.

---
 rtl/rsa_modexp_ctrl_if.sv | 23 ++
 rtl/rsa_modexp_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_ctrl_if.sv
`timescale 1ns/1ps
// rsa_modexp_ctrl_if: start/finish handshake and operand bus between the modexp
// sequencer (master) and the shared Montgomery product unit (slave).
interface rsa_modexp_ctrl_if #(
  parameter int W = 256
);
  logic         mp_start;
  logic [W-1:0] mp_n;
  logic [W-1:0] mp_a;
  logic [W-1:0] mp_b;
  logic [W-1:0] mp_m;
  logic         mp_finish;

  modport master (
    output mp_start, mp_n, mp_a, mp_b,
    input  mp_m, mp_finish
  );

  modport slave (
    input  mp_start, mp_n, mp_a, mp_b,
    output mp_m, mp_finish
  );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
`timescale 1ns/1ps
// rsa_modexp_ctrl: LSB-first square-and-multiply sequencer for y^d mod N over one
// shared Montgomery product unit; the result is held until the next accepted request.
module rsa_modexp_ctrl #(
  parameter int W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [W-1:0]      i_n,
  input  logic [W-1:0]      i_d,
  input  logic [W-1:0]      i_y_mont,
  output logic [W-1:0]      o_result,
  output logic              o_finish,
  output logic              o_busy,
  rsa_modexp_ctrl_if.master mp_bus
);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_GO   = 3'd1,
    MUL_WAIT = 3'd2,
    SQR_GO   = 3'd3,
    SQR_WAIT = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [W-1:0]  n_r, d_r, t_r, m_r;
  logic [W-1:0]  n_nxt_s, d_nxt_s, t_nxt_s, m_nxt_s;
  logic [IW-1:0] i_r, i_nxt_s, i_inc_s;
  logic          mp_start_r, mp_start_nxt_s;
  logic [W-1:0]  mp_a_r, mp_b_r, mp_a_nxt_s, mp_b_nxt_s;
  logic [W-1:0]  o_result_r, o_result_nxt_s;
  logic          o_finish_r, o_finish_nxt_s;
  logic          o_busy_r, o_busy_nxt_s;

  assign i_inc_s = i_r + IW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: bit LAST_IDX is never squared, so the chain ends after its multiply or skip.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_nxt_s = i_d[0] ? MUL_GO : SQR_GO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL_GO:   state_nxt_s = MUL_WAIT;
      MUL_WAIT: begin
        if (mp_bus.mp_finish) begin
          state_nxt_s = (i_r == LAST_IDX) ? DONE : SQR_GO;
        end else begin
          state_nxt_s = MUL_WAIT;
        end
      end
      SQR_GO:   state_nxt_s = SQR_WAIT;
      SQR_WAIT: begin
        if (!mp_bus.mp_finish) begin
          state_nxt_s = SQR_WAIT;
        end else if (d_r[i_inc_s]) begin
          state_nxt_s = MUL_GO;
        end else if (i_inc_s == LAST_IDX) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SQR_GO;
        end
      end
      DONE:     state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: operand latch on request, product write-back on mp_finish.
  always_comb begin
    n_nxt_s = n_r;
    d_nxt_s = d_r;
    t_nxt_s = t_r;
    m_nxt_s = m_r;
    i_nxt_s = i_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          n_nxt_s = i_n;
          d_nxt_s = i_d;
          t_nxt_s = i_y_mont;
          m_nxt_s = {{(W-1){1'b0}}, 1'b1};
          i_nxt_s = {IW{1'b0}};
        end else begin
          n_nxt_s = n_r;
        end
      end
      MUL_WAIT: begin
        if (mp_bus.mp_finish) begin
          m_nxt_s = mp_bus.mp_m;
        end else begin
          m_nxt_s = m_r;
        end
      end
      SQR_WAIT: begin
        if (mp_bus.mp_finish) begin
          t_nxt_s = mp_bus.mp_m;
          i_nxt_s = i_inc_s;
        end else begin
          t_nxt_s = t_r;
        end
      end
      default: begin
        m_nxt_s = m_r;
      end
    endcase
  end

  // Output decode on the next state, so every output leaves a flop aligned with its state.
  always_comb begin
    mp_start_nxt_s = 1'b0;
    o_finish_nxt_s = 1'b0;
    mp_a_nxt_s     = mp_a_r;
    mp_b_nxt_s     = mp_b_r;
    o_result_nxt_s = o_result_r;
    o_busy_nxt_s   = (state_nxt_s != IDLE);
    case (state_nxt_s)
      MUL_GO: begin
        mp_start_nxt_s = 1'b1;
        mp_a_nxt_s     = m_nxt_s;
        mp_b_nxt_s     = t_nxt_s;
      end
      SQR_GO: begin
        mp_start_nxt_s = 1'b1;
        mp_a_nxt_s     = t_nxt_s;
        mp_b_nxt_s     = t_nxt_s;
      end
      DONE: begin
        o_finish_nxt_s = 1'b1;
        o_result_nxt_s = m_nxt_s;
      end
      default: begin
        mp_start_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r        <= {W{1'b0}};
      d_r        <= {W{1'b0}};
      t_r        <= {W{1'b0}};
      m_r        <= {W{1'b0}};
      i_r        <= {IW{1'b0}};
      mp_start_r <= 1'b0;
      mp_a_r     <= {W{1'b0}};
      mp_b_r     <= {W{1'b0}};
      o_result_r <= {W{1'b0}};
      o_finish_r <= 1'b0;
      o_busy_r   <= 1'b0;
    end else begin
      n_r        <= n_nxt_s;
      d_r        <= d_nxt_s;
      t_r        <= t_nxt_s;
      m_r        <= m_nxt_s;
      i_r        <= i_nxt_s;
      mp_start_r <= mp_start_nxt_s;
      mp_a_r     <= mp_a_nxt_s;
      mp_b_r     <= mp_b_nxt_s;
      o_result_r <= o_result_nxt_s;
      o_finish_r <= o_finish_nxt_s;
      o_busy_r   <= o_busy_nxt_s;
    end
  end

  assign mp_bus.mp_start = mp_start_r;
  assign mp_bus.mp_n     = n_r;
  assign mp_bus.mp_a     = mp_a_r;
  assign mp_bus.mp_b     = mp_b_r;
  assign o_result        = o_result_r;
  assign o_finish        = o_finish_r;
  assign o_busy          = o_busy_r;
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
`timescale 1ns/1ps
// tb_rsa_modexp_ctrl: directed runs against a Montgomery product-unit model; a monitor
// pops queued expectations on each o_finish (result, latency, product count, protocol).
module tb_rsa_modexp_ctrl;
  localparam int W         = 256;
  localparam int FULL_LAT  = 258;
  localparam int SHORT_LAT = 4;
  localparam logic [W-1:0] N_RSA = 256'h9F3C_2B71_E8A4_5D06_C3B9_7E12_4F8A_D561_0B7E_93C4_2AF1_68D5_E47B_0C39_A812_5F6D;
  localparam logic [W-1:0] Y_RSA = 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
  localparam logic [W-1:0] D_TOP = 256'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0011;

  typedef struct {
    logic [W-1:0] result;
    int           fin_cyc;
    int           nprod;
    string        name;
  } exp_t;

  logic         clk, rst, i_start;
  logic [W-1:0] i_n, i_d, i_y_mont, o_result;
  logic         o_finish, o_busy;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           lat = FULL_LAT;
  exp_t         sb_q[$];

  rsa_modexp_ctrl_if #(.W(W)) mp_if ();

  rsa_modexp_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_n(i_n), .i_d(i_d),
    .i_y_mont(i_y_mont), .o_result(o_result), .o_finish(o_finish),
    .o_busy(o_busy), .mp_bus(mp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Bit-serial Montgomery product a*b*2^-W mod n.
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] n);
    logic [W+1:0] u;
    u = '0;
    for (int k = 0; k < W; k++) begin
      if (a[k]) u = u + {2'b00, b};
      if (u[0]) u = u + {2'b00, n};
      u = u >> 1;
    end
    if (u >= {2'b00, n}) u = u - {2'b00, n};
    return u[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] y, input logic [W-1:0] n);
    logic [2*W-1:0] t, r;
    t = {y, {W{1'b0}}};
    r = t % {{W{1'b0}}, n};
    return r[W-1:0];
  endfunction

  // Plain-integer reference for y^d mod n.
  function automatic logic [W-1:0] modexp(input logic [W-1:0] y, input logic [W-1:0] d,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] r, b, nn;
    nn = {{W{1'b0}}, n};
    r  = {{(2*W-1){1'b0}}, 1'b1};
    b  = {{W{1'b0}}, y} % nn;
    for (int k = 0; k < W; k++) begin
      if (d[k]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[W-1:0];
  endfunction

  task automatic kick(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] y);
    i_n      = n;
    i_d      = d;
    i_y_mont = to_mont(y, n);
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  task automatic start_run(input string name, input logic [W-1:0] n, input logic [W-1:0] d,
                           input logic [W-1:0] y, input logic [W-1:0] want);
    exp_t e;
    e.name    = name;
    e.result  = want;
    e.nprod   = (W - 1) + $countones(d);
    e.fin_cyc = cyc + 1 + (lat + 1) * e.nprod;
    sb_q.push_back(e);
    kick(n, d, y);
  endtask

  task automatic wait_done(input int limit, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!o_finish && k < limit);
    if (!o_finish) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no o_finish within %0d cycles", name, limit);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_o_result"}, o_result, '0);
    check({tag, "_mp_a"}, mp_if.mp_a, '0);
    check({tag, "_mp_b"}, mp_if.mp_b, '0);
    check({tag, "_mp_n"}, mp_if.mp_n, '0);
    check({tag, "_ctrl"}, W'({o_finish, o_busy, mp_if.mp_start}), '0);
  endtask

  // Product unit model: mp_finish lands 'lat' cycles after mp_start is sampled.
  initial begin : unit_model
    int           cnt;
    logic [W-1:0] res;
    cnt = 0;
    res = '0;
    mp_if.mp_finish = 1'b0;
    mp_if.mp_m      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        mp_if.mp_finish = 1'b0;
      end else begin
        mp_if.mp_finish = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mp_if.mp_finish = 1'b1;
            mp_if.mp_m      = res;
          end
        end
        if (mp_if.mp_start) begin
          cnt = lat;
          res = mont(mp_if.mp_a, mp_if.mp_b, mp_if.mp_n);
        end
      end
    end
  end

  // Monitor: protocol bookkeeping every cycle, scoreboard comparison on o_finish.
  initial begin : monitor
    int           nprod, viol;
    bit           outst, prev_start, prev_fin, run;
    logic [W-1:0] la, lb, ln;
    exp_t         e;
    nprod = 0; viol = 0; outst = 0; prev_start = 0; prev_fin = 0; run = 0;
    la = '0; lb = '0; ln = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nprod = 0; viol = 0; outst = 0; prev_start = 0; prev_fin = 0; run = 0;
      end else begin
        if (mp_if.mp_start) begin
          if (prev_start || outst) viol++;
          nprod++;
          outst = 1'b1;
          la = mp_if.mp_a; lb = mp_if.mp_b; ln = mp_if.mp_n;
        end else if (outst && {mp_if.mp_a, mp_if.mp_b, mp_if.mp_n} !== {la, lb, ln}) begin
          viol++;
        end
        if (mp_if.mp_finish) outst = 1'b0;
        if (o_busy) run = 1'b1;
        else if (run) viol++;
        if (o_finish && prev_fin) viol++;
        if (o_finish) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_finish: o_finish at cycle %0d with nothing queued", cyc);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_result"}, o_result, e.result);
            check({e.name, "_finish_cycle"}, W'(cyc), W'(e.fin_cyc));
            check({e.name, "_products"}, W'(nprod), W'(e.nprod));
            check({e.name, "_protocol"}, W'(viol), '0);
          end
          nprod = 0; viol = 0; run = 0;
        end
        prev_start = mp_if.mp_start;
        prev_fin   = o_finish;
      end
    end
  end

  initial begin : driver
    logic [W-1:0] exp_65537, exp_top;
    exp_65537 = modexp(Y_RSA, 256'd65537, N_RSA);
    exp_top   = modexp(Y_RSA, D_TOP, N_RSA);
    rst = 1'b1; i_start = 1'b0; i_n = '0; i_d = '0; i_y_mont = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full-latency run; a mid-run request with other operands must be ignored.
    lat = FULL_LAT;
    start_run("n13_d3", 256'd13, 256'd3, 256'd5, 256'd8);
    repeat (999) @(negedge clk);
    i_n = N_RSA; i_d = '1; i_y_mont = Y_RSA; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(70000, "n13_d3");

    @(negedge clk);
    lat = SHORT_LAT;
    start_run("n13_d0", 256'd13, 256'd0, 256'd5, 256'd1);
    wait_done(3000, "n13_d0");
    i_d = '1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_in_done_ignored", W'(o_busy), '0);

    start_run("rsa_d1", N_RSA, 256'd1, Y_RSA, Y_RSA);
    wait_done(3000, "rsa_d1");
    @(negedge clk);
    start_run("rsa_d65537", N_RSA, 256'd65537, Y_RSA, exp_65537);
    wait_done(3000, "rsa_d65537");

    // Asynchronous abort mid-run, then a fresh run from scratch.
    @(negedge clk);
    kick(N_RSA, D_TOP, Y_RSA);
    repeat (500) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run("rsa_dtop", N_RSA, D_TOP, Y_RSA, exp_top);
    wait_done(3000, "rsa_dtop");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", W'(sb_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
